// File: rtl/base_crdt_gate.sv
// Credit-gated valid/ready stage with a single registered output.
// Loads its credit budget after reset and reclaims one credit per return pulse.
module base_crdt_gate #(
    parameter int width  = 8,
    parameter int cwidth = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [cwidth-1:0] i_init,
    input  logic              i_v,
    output logic              i_r,
    input  logic [width-1:0]  i_d,
    output logic              o_v,
    input  logic              o_r,
    output logic [width-1:0]  o_d,
    input  logic              i_crd_rtn,
    output logic [cwidth-1:0] o_crd,
    output logic              o_err
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [cwidth-1:0] cnt_q, cnt_d;
    logic [cwidth-1:0] init_q, init_d;
    logic              ov_q, ov_d;
    logic [width-1:0]  od_q, od_d;
    logic              err_q, err_d;
    logic              rdy;
    logic              acc;

    // State, credit count, captured limit and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            init_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            err_q   <= err_d;
        end
    end

    // Next-state: load budget once, then gate traffic on remaining credit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        ov_d    = ov_q;
        od_d    = od_q;
        err_d   = err_q;
        rdy     = 1'b0;
        acc     = 1'b0;
        unique case (state_q)
            LOAD: begin
                state_d = RUN;
                cnt_d   = i_init;
                init_d  = i_init;
                if (i_crd_rtn) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                rdy = (cnt_q != '0) & (~ov_q | o_r);
                acc = i_v & rdy;
                if (acc) begin
                    od_d = i_d;
                    ov_d = 1'b1;
                end else if (o_r) begin
                    ov_d = 1'b0;
                end
                if (acc & ~i_crd_rtn) begin
                    cnt_d = cnt_q - cwidth'(1);
                end else if (i_crd_rtn & ~acc) begin
                    // A return with the full budget already present is bogus
                    if (cnt_q == init_q) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cwidth'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign i_r   = rdy;
    assign o_v   = ov_q;
    assign o_d   = od_q;
    assign o_crd = cnt_q;
    assign o_err = err_q;

endmodule

// File: tb/tb_base_crdt_gate.sv
// Self-checking bench for base_crdt_gate.
// Directed scenarios plus randomized traffic against a transaction model.
module tb_base_crdt_gate;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] i_init;
    logic       i_v;
    logic       i_r;
    logic [7:0] i_d;
    logic       o_v;
    logic       o_r;
    logic [7:0] o_d;
    logic       i_crd_rtn;
    logic [3:0] o_crd;
    logic       o_err;

    int checks   = 0;
    int failures = 0;

    // model: credits, captured budget, sticky error, pending output beats
    bit         m_run;
    int         m_cnt;
    int         m_init;
    bit         m_err;
    logic [7:0] m_q[$];
    bit         m_ir;
    logic       ir_seen;

    base_crdt_gate #(.width(8), .cwidth(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_init    (i_init),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_d       (i_d),
        .o_v       (o_v),
        .o_r       (o_r),
        .o_d       (o_d),
        .i_crd_rtn (i_crd_rtn),
        .o_crd     (o_crd),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic v,
                        input logic [7:0] d, input logic ordy,
                        input logic rtn, input logic [3:0] init);
        bit acc;
        reset     = rst;
        i_v       = v;
        i_d       = d;
        o_r       = ordy;
        i_crd_rtn = rtn;
        i_init    = init;
        #2;
        ir_seen = i_r;
        m_ir = m_run && (m_cnt != 0) && (m_q.size() == 0 || ordy);
        @(posedge clk);
        if (rst) begin
            m_run = 0;
            m_cnt = 0;
            m_err = 0;
            m_q.delete();
        end else if (!m_run) begin
            m_run  = 1;
            m_init = int'(init);
            m_cnt  = int'(init);
            if (rtn) m_err = 1;
        end else begin
            acc = v && m_ir;
            if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
            if (acc) m_q.push_back(d);
            if (acc && !rtn) m_cnt = m_cnt - 1;
            else if (rtn && !acc) begin
                if (m_cnt == m_init) m_err = 1;
                else m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00, 1, 0, 4'd3);
        step(1, 0, 8'h00, 1, 0, 4'd3);
        checks++;
        if (o_v !== 1'b0) begin
            failures++;
            $display("FAIL reset_ov got=%0b exp=0", o_v);
        end
        checks++;
        if (o_crd !== 4'd0) begin
            failures++;
            $display("FAIL reset_crd got=%0d exp=0", o_crd);
        end
        checks++;
        if (o_err !== 1'b0 || o_d !== 8'h00) begin
            failures++;
            $display("FAIL reset_err_od got=%0b/%0h exp=0/0", o_err, o_d);
        end
        checks++;
        if (i_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_ir got=%0b exp=0", i_r);
        end
    endtask

    task automatic test_basic();
        logic [7:0] dat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int exp_crd[4] = '{2, 1, 0, 0};
        int idx = 0;
        step(0, 0, 8'h00, 1, 0, 4'd3);
        checks++;
        if (o_crd !== 4'd3) begin
            failures++;
            $display("FAIL load_crd got=%0d exp=3", o_crd);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, dat[idx], 1, 0, 4'd3);
            checks++;
            if (ir_seen !== (k < 3)) begin
                failures++;
                $display("FAIL basic_ir[%0d] got=%0b exp=%0b", k, ir_seen, k < 3);
            end
            if (ir_seen === 1'b1) idx++;
            checks++;
            if (o_crd !== 4'(exp_crd[k])) begin
                failures++;
                $display("FAIL basic_crd[%0d] got=%0d exp=%0d", k, o_crd, exp_crd[k]);
            end
            checks++;
            if (o_v !== (k < 3) || (k < 3 && o_d !== dat[k])) begin
                failures++;
                $display("FAIL basic_out[%0d] got=%0b/%0h exp=%0b/%0h",
                         k, o_v, o_d, k < 3, dat[k]);
            end
        end
    endtask

    task automatic test_return();
        step(0, 1, 8'h44, 1, 1, 4'd3);
        checks++;
        if (ir_seen !== 1'b0 || o_crd !== 4'd1 || o_v !== 1'b0) begin
            failures++;
            $display("FAIL rtn_first got ir=%0b crd=%0d ov=%0b exp 0/1/0",
                     ir_seen, o_crd, o_v);
        end
        step(0, 1, 8'h44, 1, 0, 4'd3);
        checks++;
        if (ir_seen !== 1'b1 || o_crd !== 4'd0) begin
            failures++;
            $display("FAIL rtn_use got ir=%0b crd=%0d exp 1/0", ir_seen, o_crd);
        end
        checks++;
        if (o_v !== 1'b1 || o_d !== 8'h44 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL rtn_out got=%0b/%0h/%0b exp=1/44/0", o_v, o_d, o_err);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 8'h00, 1, 0, 4'd2);
        step(0, 0, 8'h00, 1, 0, 4'd2);
        step(0, 1, 8'h11, 1, 0, 4'd2);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 8'h22, 0, 0, 4'd2);
            checks++;
            if (ir_seen !== 1'b0 || o_v !== 1'b1 || o_d !== 8'h11) begin
                failures++;
                $display("FAIL stall_hold[%0d] got ir=%0b ov=%0b od=%0h exp 0/1/11",
                         k, ir_seen, o_v, o_d);
            end
        end
        step(0, 1, 8'h22, 1, 0, 4'd2);
        checks++;
        if (ir_seen !== 1'b1 || o_d !== 8'h22 || o_crd !== 4'd0) begin
            failures++;
            $display("FAIL stall_release got ir=%0b od=%0h crd=%0d exp 1/22/0",
                     ir_seen, o_d, o_crd);
        end
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        step(1, 0, 8'h00, 1, 0, 4'd1);
        step(0, 0, 8'h00, 1, 0, 4'd1);
        step(0, 1, 8'h01, 1, 0, 4'd1);
        step(0, 1, 8'h02, 1, 1, 4'd1);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 8'(8'h10 + k), 1, 1, 4'd1);
            if (ir_seen === 1'b1) beats++;
            checks++;
            if (o_crd !== 4'(m_cnt) || o_v !== 1'b1 || o_d !== 8'(8'h10 + k)) begin
                failures++;
                $display("FAIL b2b[%0d] got crd=%0d ov=%0b od=%0h exp %0d/1/%0h",
                         k, o_crd, o_v, o_d, m_cnt, 8'h10 + k);
            end
        end
        checks++;
        if (beats != 8 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_rate got beats=%0d err=%0b exp 8/0", beats, o_err);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 8'h00, 1, 0, 4'd2);
        step(0, 0, 8'h00, 1, 0, 4'd2);
        step(0, 0, 8'h00, 1, 0, 4'd2);
        step(0, 0, 8'h00, 1, 1, 4'd2);
        checks++;
        if (o_crd !== 4'd2 || o_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf got crd=%0d err=%0b exp 2/1", o_crd, o_err);
        end
        step(1, 0, 8'h00, 1, 0, 4'd2);
        step(0, 0, 8'h00, 1, 0, 4'd2);
        checks++;
        if (o_crd !== 4'd2 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got crd=%0d err=%0b exp 2/0", o_crd, o_err);
        end
    endtask

    task automatic test_zero_init();
        step(1, 0, 8'h00, 1, 0, 4'd0);
        step(0, 0, 8'h00, 1, 0, 4'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h77, 1, 0, 4'd5);
        checks++;
        if (ir_seen !== 1'b0 || o_v !== 1'b0 || o_err !== 1'b0 || o_crd !== 4'd0) begin
            failures++;
            $display("FAIL zero_init got ir=%0b ov=%0b err=%0b crd=%0d exp 0/0/0/0",
                     ir_seen, o_v, o_err, o_crd);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 0, 8'h00, 1, 0, 4'd3);
        step(0, 0, 8'h00, 1, 0, 4'd3);
        step(0, 1, 8'hAA, 1, 0, 4'd3);
        step(0, 1, 8'hBB, 0, 0, 4'd3);
        step(1, 1, 8'hBB, 0, 0, 4'd3);
        checks++;
        if (o_v !== 1'b0 || o_crd !== 4'd0) begin
            failures++;
            $display("FAIL midrst got ov=%0b crd=%0d exp 0/0", o_v, o_crd);
        end
        step(0, 1, 8'h5A, 1, 0, 4'd3);
        checks++;
        if (o_crd !== 4'd3 || o_v !== 1'b0) begin
            failures++;
            $display("FAIL midrst_load got crd=%0d ov=%0b exp 3/0", o_crd, o_v);
        end
        step(0, 1, 8'h5A, 1, 0, 4'd3);
        checks++;
        if (o_v !== 1'b1 || o_d !== 8'h5A || o_crd !== 4'd2) begin
            failures++;
            $display("FAIL midrst_resume got ov=%0b od=%0h crd=%0d exp 1/5a/2",
                     o_v, o_d, o_crd);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(99) < 3), $urandom_range(1), 8'($urandom),
                 ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                 4'($urandom_range(15)));
            checks++;
            if (ir_seen !== m_ir || o_v !== (m_q.size() != 0) ||
                o_crd !== 4'(m_cnt) || o_err !== m_err ||
                (m_q.size() != 0 && o_d !== m_q[0])) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand[%0d] got ir=%0b ov=%0b od=%0h crd=%0d err=%0b exp ir=%0b ov=%0b od=%0h crd=%0d err=%0b",
                             k, ir_seen, o_v, o_d, o_crd, o_err, m_ir,
                             m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 8'h00,
                             m_cnt, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; i_v = 1'b0; i_d = '0; o_r = 1'b1;
        i_crd_rtn = 1'b0; i_init = 4'd3;
        m_run = 0; m_cnt = 0; m_init = 0; m_err = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_return();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_zero_init();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
